// File: rtl/mem_bus_fabric_if.sv
// Native memory bus bundles: master-side request/response and the
// broadcast slave-side channel group of the fabric.

// valid/ready: a requester raises valid with address/data/strobes stable and
// holds them until it samples ready high on a rising edge; that edge completes
// the transfer. ready is a single-cycle response, and rdata is valid only while
// ready is high. wstrb == 0 denotes a read.
interface mem_bus_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );
  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

interface slv_bus_if #(parameter int NSLV = 4);
  logic [NSLV-1:0]    slv_valid;
  logic [NSLV-1:0]    slv_ready;
  logic [NSLV*32-1:0] slv_rdata;
  logic [31:0]        slv_addr;
  logic [31:0]        slv_wdata;
  logic [3:0]         slv_wstrb;

  modport master (
    output slv_valid, slv_addr, slv_wdata, slv_wstrb,
    input  slv_ready, slv_rdata
  );
  modport slave (
    input  slv_valid, slv_addr, slv_wdata, slv_wstrb,
    output slv_ready, slv_rdata
  );
endinterface

// File: rtl/mem_bus_fabric.sv
// One-master, NSLV-slave memory bus fabric with base/mask decode, a per-
// transaction registered slave select and error termination of unmapped/hung accesses.
module mem_bus_fabric #(
  parameter int                 NSLV     = 4,
  parameter logic [NSLV*32-1:0] SLV_BASE = {32'h90000000, 32'h80000000, 32'h30000000, 32'h00000000},
  parameter logic [NSLV*32-1:0] SLV_MASK = {4{32'hF0000000}},
  parameter int                 TIMEOUT  = 1024,
  parameter logic [31:0]        ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  mem_bus_if.slave    mem,
  slv_bus_if.master   slv,
  output logic        err_pulse,
  output logic [1:0]  err_code,
  output logic [31:0] err_addr,
  output logic [15:0] err_count,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERR    = 2'd2
  } state_t;

  localparam int             WDW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;

  state_t          state;
  state_t          state_nxt;
  logic [NSLV-1:0] sel;
  logic [NSLV-1:0] hit_oh;
  logic            any_hit;
  logic [WDW-1:0]  wdog;
  logic            wd_expired;
  logic            sel_ready;
  logic [31:0]     sel_rdata;
  logic            err_set;
  logic [1:0]      err_code_set;

  // Scan from the top index down so the lowest matching region overwrites the rest.
  always_comb begin
    hit_oh  = '0;
    any_hit = 1'b0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((mem.mem_addr & SLV_MASK[32*i +: 32]) == (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32])) begin
        hit_oh    = '0;
        hit_oh[i] = 1'b1;
        any_hit   = 1'b1;
      end
    end
  end

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel[i]) sel_rdata = sel_rdata | slv.slv_rdata[32*i +: 32];
    end
  end

  assign sel_ready  = |(slv.slv_ready & sel);
  assign wd_expired = (TIMEOUT != 0) && (wdog == WD_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Ready outranks both the valid-drop abort and the watchdog threshold.
  always_comb begin
    state_nxt    = state;
    err_set      = 1'b0;
    err_code_set = 2'b00;
    case (state)
      ST_IDLE: begin
        if (mem.mem_valid) begin
          if (any_hit) begin
            state_nxt = ST_ACTIVE;
          end else begin
            state_nxt    = ST_ERR;
            err_set      = 1'b1;
            err_code_set = 2'b01;
          end
        end
      end
      ST_ACTIVE: begin
        if (sel_ready) begin
          state_nxt = ST_IDLE;
        end else if (!mem.mem_valid) begin
          state_nxt = ST_IDLE;
        end else if (wd_expired) begin
          state_nxt    = ST_ERR;
          err_set      = 1'b1;
          err_code_set = 2'b10;
        end
      end
      ST_ERR:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    slv.slv_valid  = '0;
    mem.mem_ready  = 1'b0;
    mem.mem_rdata  = '0;
    err_pulse      = 1'b0;
    case (state)
      ST_ACTIVE: begin
        slv.slv_valid = sel & {NSLV{mem.mem_valid}};
        mem.mem_ready = sel_ready;
        mem.mem_rdata = sel_rdata;
      end
      ST_ERR: begin
        mem.mem_ready = 1'b1;
        mem.mem_rdata = ERR_DATA;
        err_pulse     = 1'b1;
      end
      default: ;
    endcase
  end

  // Error status updates on the edge entering ERR, so it is already current
  // during the error response cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel       <= '0;
      wdog      <= '0;
      err_code  <= 2'b00;
      err_addr  <= '0;
      err_count <= '0;
    end else begin
      if (state == ST_IDLE && mem.mem_valid && any_hit) begin
        sel  <= hit_oh;
        wdog <= '0;
      end else if (state == ST_ACTIVE && state_nxt == ST_ACTIVE) begin
        wdog <= wdog + WDW'(1);
      end
      if (err_set) begin
        err_code <= err_code_set;
        err_addr <= mem.mem_addr;
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end
    end
  end

  assign slv.slv_addr  = mem.mem_addr;
  assign slv.slv_wdata = mem.mem_wdata;
  assign slv.slv_wstrb = mem.mem_wstrb;
  assign dbg_state     = state;

endmodule

// File: tb/tb_mem_bus_fabric.sv
// Randomized bench for mem_bus_fabric: a behavioural model predicts slave
// choice, response cycle, read data and error status for each transaction.
module tb_mem_bus_fabric;
  localparam int                 NSLV     = 4;
  localparam int                 TO       = 8;
  localparam logic [NSLV*32-1:0] BASE     = {32'h90000000, 32'h80000000, 32'h30000000, 32'h00000000};
  localparam logic [NSLV*32-1:0] MASK     = {4{32'hF0000000}};
  localparam logic [NSLV*32-1:0] OV_MASK  = {32'hF0000000, 32'hF0000000, 32'hF0000000, 32'h00000000};
  localparam logic [31:0]        ERR_DATA = 32'hDEADBEEF;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_bus_if                   mbus ();
  slv_bus_if #(.NSLV(NSLV))    sbus ();
  mem_bus_if                   ov_m ();
  slv_bus_if #(.NSLV(NSLV))    ov_s ();

  logic        err_pulse, ov_err_pulse;
  logic [1:0]  err_code, ov_err_code;
  logic [31:0] err_addr, ov_err_addr;
  logic [15:0] err_count, ov_err_count;
  logic [1:0]  dbg_state, ov_dbg_state;

  mem_bus_fabric #(.NSLV(NSLV), .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(TO), .ERR_DATA(ERR_DATA)) dut (
    .clk(clk), .rst(rst), .mem(mbus), .slv(sbus),
    .err_pulse(err_pulse), .err_code(err_code), .err_addr(err_addr),
    .err_count(err_count), .dbg_state(dbg_state)
  );

  mem_bus_fabric #(.NSLV(NSLV), .SLV_BASE(BASE), .SLV_MASK(OV_MASK)) dut_ov (
    .clk(clk), .rst(rst), .mem(ov_m), .slv(ov_s),
    .err_pulse(ov_err_pulse), .err_code(ov_err_code), .err_addr(ov_err_addr),
    .err_count(ov_err_count), .dbg_state(ov_dbg_state)
  );

  // scoreboard
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [1:0]  m_code;
  logic [31:0] m_addr;
  int          m_count;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < NSLV; i++)
      if ((a & MASK[32*i +: 32]) == (BASE[32*i +: 32] & MASK[32*i +: 32])) return i;
    return -1;
  endfunction

  // Issue one request at the current negedge (fabric idle). dly = cycles of
  // slv_valid before the target raises ready; dly >= TO means it never does.
  task automatic do_access(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int dly, input bit wiggle);
    int              s, resp_cyc;
    bit              is_err;
    logic [1:0]      ecode;
    logic [31:0]     cur_addr;
    logic [NSLV-1:0] oh, exp_sv, noise;
    s = ref_decode(addr);
    oh = '0;
    if (s >= 0) oh[s] = 1'b1;
    if (s < 0)         begin is_err = 1'b1; ecode = 2'b01; resp_cyc = 1;       end
    else if (dly >= TO) begin is_err = 1'b1; ecode = 2'b10; resp_cyc = TO + 1;  end
    else               begin is_err = 1'b0; ecode = 2'b00; resp_cyc = dly + 1; end
    exp_q.push_back(is_err ? ERR_DATA : sbus.slv_rdata[32*s +: 32]);

    check("idle_ready", 32'(mbus.mem_ready), 32'd0);
    check("idle_slv_valid", 32'(sbus.slv_valid), 32'd0);
    mbus.mem_valid = 1'b1;
    mbus.mem_addr  = addr;
    mbus.mem_wdata = wdata;
    mbus.mem_wstrb = wstrb;
    cur_addr = addr;
    for (int cyc = 1; cyc <= resp_cyc; cyc++) begin
      @(negedge clk);
      noise = NSLV'($urandom) & ~oh;
      sbus.slv_ready = noise | ((!is_err && cyc == resp_cyc) ? oh : '0);
      #1;
      exp_sv = (is_err && cyc == resp_cyc) ? '0 : oh;
      check("slv_valid", 32'(sbus.slv_valid), 32'(exp_sv));
      check("mem_ready", 32'(mbus.mem_ready), 32'(cyc == resp_cyc));
      check("err_pulse", 32'(err_pulse), 32'(is_err && cyc == resp_cyc));
      check("slv_addr", sbus.slv_addr, cur_addr);
      if (cyc == 1) begin
        check("slv_wdata", sbus.slv_wdata, wdata);
        check("slv_wstrb", 32'(sbus.slv_wstrb), 32'(wstrb));
      end
      if (cyc == resp_cyc) begin
        check("mem_rdata", mbus.mem_rdata, exp_q.pop_front());
        if (is_err) begin
          m_code = ecode;
          m_addr = cur_addr;
          if (m_count < 65535) m_count++;
        end
        check("err_code", 32'(err_code), 32'(m_code));
        check("err_addr", err_addr, m_addr);
        check("err_count", 32'(err_count), 32'(m_count));
      end else if (wiggle && !is_err) begin
        cur_addr = $urandom;
        mbus.mem_addr = cur_addr;
      end
    end
    mbus.mem_valid = 1'b0;
    sbus.slv_ready = '0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n + 1) @(negedge clk);
  endtask

  initial begin
    logic [3:0]  nibs [5];
    logic [31:0] a;
    int          dly;
    nibs = '{4'h0, 4'h3, 4'h8, 4'h9, 4'h5};
    m_code = 2'b00; m_addr = '0; m_count = 0;
    rst = 1'b1;
    mbus.mem_valid = 1'b0; mbus.mem_addr = '0; mbus.mem_wdata = '0; mbus.mem_wstrb = '0;
    sbus.slv_ready = '0;
    sbus.slv_rdata = {32'h44444444, 32'h33333333, 32'h22222222, 32'h12345678};
    ov_m.mem_valid = 1'b0; ov_m.mem_addr = '0; ov_m.mem_wdata = '0; ov_m.mem_wstrb = '0;
    ov_s.slv_ready = '0;
    ov_s.slv_rdata = {32'h99999999, 32'h88888888, 32'h77777777, 32'h0BADF00D};

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(mbus.mem_ready), 32'd0);
    check("rst_rdata", mbus.mem_rdata, 32'd0);
    check("rst_slv_valid", 32'(sbus.slv_valid), 32'd0);
    check("rst_err_pulse", 32'(err_pulse), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_err_addr", err_addr, 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // directed: read slave0 with delay 3, write slave1 immediate ready
    do_access(32'h00000010, 32'h0, 4'b0000, 3, 1'b0);
    idle_cycles(0);
    do_access(32'h30000004, 32'hA5A5A5A5, 4'b0011, 0, 1'b0);
    idle_cycles(1);

    // reset in the middle of an ACTIVE transaction
    mbus.mem_valid = 1'b1; mbus.mem_addr = 32'h80000010; mbus.mem_wstrb = 4'b0000;
    repeat (3) @(negedge clk);
    check("pre_rst_slv_valid", 32'(sbus.slv_valid), 32'h4);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rst_slv_valid", 32'(sbus.slv_valid), 32'd0);
    check("mid_rst_ready", 32'(mbus.mem_ready), 32'd0);
    check("mid_rst_err_count", 32'(err_count), 32'd0);
    rst = 1'b0;
    mbus.mem_valid = 1'b0;
    idle_cycles(0);
    do_access(32'h00000020, 32'h0, 4'b0000, 1, 1'b0);
    idle_cycles(0);

    // unmapped, timeout, ready exactly at the threshold
    do_access(32'h50000000, 32'h0, 4'b0000, 0, 1'b0);
    idle_cycles(0);
    do_access(32'h80000000, 32'h0, 4'b0000, TO, 1'b0);
    idle_cycles(0);
    do_access(32'h80000000, 32'h0, 4'b0000, TO - 1, 1'b0);
    idle_cycles(0);

    // master drops valid without a response: silent abort
    mbus.mem_valid = 1'b1; mbus.mem_addr = 32'h30000000;
    repeat (3) @(negedge clk);
    mbus.mem_valid = 1'b0;
    @(negedge clk);
    #1;
    check("abort_ready", 32'(mbus.mem_ready), 32'd0);
    check("abort_slv_valid", 32'(sbus.slv_valid), 32'd0);
    @(negedge clk);
    check("abort_err_pulse", 32'(err_pulse), 32'd0);
    check("abort_err_count", 32'(err_count), 32'(m_count));

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      a = $urandom;
      if ($urandom_range(0, 5) != 0) a[31:28] = nibs[$urandom_range(0, 4)];
      dly = ($urandom_range(0, 3) == 0) ? $urandom_range(TO - 1, TO + 2) : $urandom_range(0, 5);
      sbus.slv_rdata = {$urandom, $urandom, $urandom, $urandom};
      do_access(a, $urandom, 4'($urandom), dly, 1'($urandom));
      idle_cycles($urandom_range(0, 2));
    end

    // overlapping map: slave0 covers everything and must win
    for (int k = 0; k < 2; k++) begin
      ov_m.mem_valid = 1'b1;
      ov_m.mem_addr  = (k == 0) ? 32'h90000000 : 32'h30000008;
      ov_s.slv_ready = 4'b1001;
      @(negedge clk);
      #1;
      check("ov_slv_valid", 32'(ov_s.slv_valid), 32'h1);
      check("ov_ready", 32'(ov_m.mem_ready), 32'd1);
      check("ov_rdata", ov_m.mem_rdata, 32'h0BADF00D);
      ov_m.mem_valid = 1'b0;
      ov_s.slv_ready = '0;
      @(negedge clk);
    end

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
